// File: rtl/frog_pkg.sv
// Shared constants for the frog game datapath: random source and comparator widths.
// No latency; declarations only.
// No flow control; declarations only.
package frog_pkg;

  // Random operand width; the a<b comparator operands are sized from this.
  localparam int RAND_W = 10;

  // x^10 + x^7 + 1 expressed on state bits 9 and 6; maximal length, period 1023.
  localparam logic [RAND_W-1:0] LFSR_TAPS = 10'h240;

  // Power-on state, also the substitute for a zero seed (zero is the lockup state).
  localparam logic [RAND_W-1:0] LFSR_SEED = 10'h001;

  // Comparator operand type.
  typedef logic [RAND_W-1:0] rand_t;

endpackage

// File: rtl/tick_divider.sv
// Prescaler: emits tick on the enabled cycle that completes every DIV enabled cycles.
// Latency: tick is combinational from enable and the registered count (zero cycles).
// No backpressure: count holds while enable is low; clear restarts the phase.
module tick_divider #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  // A one-bit counter is kept even for DIV=1 so the port/compare widths stay legal.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  // Phase counter: restart on clear, wrap to zero on the tick cycle, else count enabled cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/lfsr_rand_gen.sv
// Pseudo-random operand source (Fibonacci LFSR) with seed load, lockup guard and wrap flag.
// Latency: one cycle; rand_out/rand_valid/wrapped update on the edge that samples load/enable.
// No backpressure: the consumer samples rand_out whenever rand_valid pulses; state holds otherwise.
module lfsr_rand_gen
  import frog_pkg::*;
#(
  parameter int                 WIDTH        = RAND_W,
  parameter logic [WIDTH-1:0]   TAP_MASK     = LFSR_TAPS,
  parameter logic [WIDTH-1:0]   DEFAULT_SEED = LFSR_SEED,
  parameter int                 DIV          = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] rand_out,
  output logic             rand_valid,
  output logic             wrapped,
  output logic [WIDTH-1:0] step_cnt
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] seed_reg;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] seed_sel;
  logic             tick;

  // The prescaler is cleared by load so a fresh seed always starts a full DIV phase.
  tick_divider #(
    .DIV (DIV)
  ) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .clear   (load),
    .tick    (tick)
  );

  // Next LFSR value; an all-zero state can only come from a fault, so recover to the default seed.
  always_comb begin
    nxt = {state[WIDTH-2:0], ^(state & TAP_MASK)};
    if (state == '0) nxt = DEFAULT_SEED;
  end

  // A zero seed would lock the LFSR, so it is replaced by the default seed.
  assign seed_sel = (seed == '0) ? DEFAULT_SEED : seed;

  // LFSR, seed register, step counter and wrap/valid pulses; load beats enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= DEFAULT_SEED;
      seed_reg   <= DEFAULT_SEED;
      step_cnt   <= '0;
      rand_valid <= 1'b0;
      wrapped    <= 1'b0;
    end else if (load) begin
      state      <= seed_sel;
      seed_reg   <= seed_sel;
      step_cnt   <= '0;
      rand_valid <= 1'b1;
      wrapped    <= 1'b0;
    end else if (tick) begin
      state      <= nxt;
      rand_valid <= 1'b1;
      // Returning to the loaded seed marks a full period; restart the advance count.
      if (nxt == seed_reg) begin
        wrapped  <= 1'b1;
        step_cnt <= '0;
      end else begin
        wrapped  <= 1'b0;
        step_cnt <= step_cnt + WIDTH'(1);
      end
    end else begin
      rand_valid <= 1'b0;
      wrapped    <= 1'b0;
    end
  end

  assign rand_out = state;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
module tb_lfsr_rand_gen;

  logic       clk;
  logic       reset_n;

  // Instance A: DIV=1
  logic       enable_a, load_a;
  logic [9:0] seed_a;
  logic [9:0] rand_a, step_a;
  logic       valid_a, wrap_a;

  // Instance B: DIV=4
  logic       enable_b, load_b;
  logic [9:0] seed_b;
  logic [9:0] rand_b, step_b;
  logic       valid_b, wrap_b;

  int n_cmp;
  int n_bad;

  lfsr_rand_gen #(.DIV(1)) dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable_a),
    .load       (load_a),
    .seed       (seed_a),
    .rand_out   (rand_a),
    .rand_valid (valid_a),
    .wrapped    (wrap_a),
    .step_cnt   (step_a)
  );

  lfsr_rand_gen #(.DIV(4)) dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable_b),
    .load       (load_b),
    .seed       (seed_b),
    .rand_out   (rand_b),
    .rand_valid (valid_b),
    .wrapped    (wrap_b),
    .step_cnt   (step_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] exp_seq [10];
  bit         seen    [1024];
  int         wrap_cnt;
  int         wrap_at;
  int         zero_seen;
  int         dup_cnt;
  int         valid_b_cnt;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_seq = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h020,
                10'h040, 10'h081, 10'h102, 10'h204, 10'h009};

    reset_n  = 1'b0;
    enable_a = 1'b0; load_a = 1'b0; seed_a = '0;
    enable_b = 1'b0; load_b = 1'b0; seed_b = '0;

    // 1: reset state
    step();
    step();
    chk("rst_rand_a",  rand_a,  10'h001);
    chk("rst_step_a",  step_a,  10'h000);
    chk("rst_valid_a", valid_a, 1'b0);
    chk("rst_wrap_a",  wrap_a,  1'b0);
    chk("rst_rand_b",  rand_b,  10'h001);
    chk("rst_valid_b", valid_b, 1'b0);
    reset_n = 1'b1;
    step();
    chk("idle_rand_a", rand_a, 10'h001);

    // 2 and 3: run a full period with DIV=1
    for (int k = 0; k < 1024; k++) seen[k] = 1'b0;
    seen[1]   = 1'b1;
    wrap_cnt  = 0;
    wrap_at   = 0;
    zero_seen = 0;
    dup_cnt   = 0;
    enable_a  = 1'b1;
    for (int i = 1; i <= 1023; i++) begin
      step();
      if (i <= 10) begin
        chk($sformatf("seq_%0d", i), rand_a, exp_seq[i-1]);
        chk($sformatf("seq_valid_%0d", i), valid_a, 1'b1);
      end
      if (wrap_a) begin
        wrap_cnt++;
        wrap_at = i;
      end
      if (rand_a == 10'h000) zero_seen++;
      if (i < 1023) begin
        if (seen[rand_a]) dup_cnt++;
        seen[rand_a] = 1'b1;
        chk($sformatf("step_cnt_%0d", i), step_a, i);
      end else begin
        chk("wrap_rand",  rand_a, 10'h001);
        chk("wrap_step",  step_a, 10'h000);
        chk("wrap_valid", valid_a, 1'b1);
      end
    end
    chk("wrap_count",  wrap_cnt,  1);
    chk("wrap_index",  wrap_at,   1023);
    chk("zero_states", zero_seen, 0);
    chk("dup_states",  dup_cnt,   0);

    // Next advance after wrap: pulse drops, sequence continues
    step();
    chk("post_wrap_rand",  rand_a, 10'h002);
    chk("post_wrap_pulse", wrap_a, 1'b0);
    chk("post_wrap_step",  step_a, 10'h001);

    // Hold: everything frozen, pulses low
    enable_a = 1'b0;
    step();
    chk("hold_rand",  rand_a,  10'h002);
    chk("hold_valid", valid_a, 1'b0);
    chk("hold_step",  step_a,  10'h001);

    // 4: load has priority over enable
    enable_a = 1'b1; load_a = 1'b1; seed_a = 10'h3FF;
    step();
    chk("load_rand",  rand_a,  10'h3FF);
    chk("load_valid", valid_a, 1'b1);
    chk("load_step",  step_a,  10'h000);
    chk("load_wrap",  wrap_a,  1'b0);
    seed_a = 10'h000;
    step();
    chk("load0_rand", rand_a, 10'h001);
    load_a = 1'b0;
    step();
    chk("after_load_rand", rand_a, 10'h002);
    chk("after_load_step", step_a, 10'h001);

    // Advance a few more, then 6: async reset between edges
    step();
    step();
    chk("pre_rst_rand", rand_a, 10'h008);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_rand",  rand_a,  10'h001);
    chk("arst_step",  step_a,  10'h000);
    chk("arst_valid", valid_a, 1'b0);
    chk("arst_wrap",  wrap_a,  1'b0);
    #1;
    reset_n = 1'b1;
    step();
    chk("restart_rand", rand_a, 10'h002);
    chk("restart_step", step_a, 10'h001);
    enable_a = 1'b0;

    // 5: DIV=4 prescaler - enable 3 cycles, off 2, on 1 -> one advance
    valid_b_cnt = 0;
    enable_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (valid_b) valid_b_cnt++;
    end
    chk("div4_hold_rand", rand_b, 10'h001);
    enable_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (valid_b) valid_b_cnt++;
    end
    chk("div4_idle_rand", rand_b, 10'h001);
    enable_b = 1'b1;
    step();
    chk("div4_adv_rand",  rand_b,  10'h002);
    chk("div4_adv_valid", valid_b, 1'b1);
    chk("div4_adv_step",  step_b,  10'h001);
    chk("div4_early_pulses", valid_b_cnt, 0);
    enable_b = 1'b0;
    step();
    chk("div4_pulse_end", valid_b, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
